// File: rtl/arm_cond_pkg.sv
// Shared condition-code encodings and NZCV bit positions for the ARM condition logic.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package arm_cond_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Evaluates a 4-bit ARM condition field against an NZCV flag value.
// Latency: purely combinational, zero cycles.
// Backpressure: none; result is valid whenever inputs are stable.
module cond_check
  import arm_cond_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       result_o
);

  logic n, z, c, v;

  assign n = flags_i[FLAG_N];
  assign z = flags_i[FLAG_Z];
  assign c = flags_i[FLAG_C];
  assign v = flags_i[FLAG_V];

  // Decode the condition code; 1111 is treated as always.
  always_comb begin
    result_o = 1'b1;
    case (cond_e'(cond_i))
      COND_EQ: result_o = z;
      COND_NE: result_o = ~z;
      COND_CS: result_o = c;
      COND_CC: result_o = ~c;
      COND_MI: result_o = n;
      COND_PL: result_o = ~n;
      COND_VS: result_o = v;
      COND_VC: result_o = ~v;
      COND_HI: result_o = c & ~z;
      COND_LS: result_o = ~c | z;
      COND_GE: result_o = (n == v);
      COND_LT: result_o = (n != v);
      COND_GT: result_o = ~z & (n == v);
      COND_LE: result_o = z | (n != v);
      COND_AL: result_o = 1'b1;
      COND_NV: result_o = 1'b1;
      default: result_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_flag_unit.sv
// NZCV flag register plus per-instruction condition latch that gates PC/reg/mem write strobes.
// Latency: CondEx updates one edge after CondLatch; gated strobes are combinational from it.
// Backpressure: none. Optional annulled-instruction counter under COND_PERF_CNT_EN.
module cond_flag_unit
  import arm_cond_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
`ifdef COND_PERF_CNT_EN
  , parameter int unsigned CNT_W = 16
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       CondLatch,
  input  logic       PCS,
  input  logic       NextPC,
  input  logic       RegW,
  input  logic       MemW,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondEx,
  output logic [3:0] Flags
`ifdef COND_PERF_CNT_EN
  , input  logic             CntClr
  , output logic [CNT_W-1:0] AnnulCnt
`endif
);

  logic [3:0] flags_q, flags_d;
  logic       cond_ex_q, cond_ex_d;
  logic       cond_res;

  // Condition is always judged against the architectural flags, never the live ALU flags.
  cond_check u_cond_check (
    .cond_i   (Cond),
    .flags_i  (flags_q),
    .result_o (cond_res)
  );

  // Next-state: each flag half is written only when requested and the current instruction
  // is executing; the old CondEx gates the write even if a new condition latches this edge.
  always_comb begin
    flags_d   = flags_q;
    cond_ex_d = cond_ex_q;
    if (FlagW[1] && cond_ex_q) begin
      flags_d[FLAG_N] = ALUFlags[FLAG_N];
      flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
    end
    if (FlagW[0] && cond_ex_q) begin
      flags_d[FLAG_C] = ALUFlags[FLAG_C];
      flags_d[FLAG_V] = ALUFlags[FLAG_V];
    end
    if (CondLatch) begin
      cond_ex_d = cond_res;
    end
  end

  // Architectural state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q   <= RESET_FLAGS;
      cond_ex_q <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex_d;
    end
  end

  assign PCWrite  = NextPC | (PCS & cond_ex_q);
  assign RegWrite = RegW & cond_ex_q;
  assign MemWrite = MemW & cond_ex_q;
  assign CondEx   = cond_ex_q;
  assign Flags    = flags_q;

`ifdef COND_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count instructions whose condition failed at latch time; saturate, clear has priority.
  always_comb begin
    cnt_d = cnt_q;
    if (CntClr) begin
      cnt_d = '0;
    end else if (CondLatch && !cond_res && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Annulled-instruction counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign AnnulCnt = cnt_q;
`endif

endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed self-checking bench for cond_flag_unit (table vectors plus multi-cycle sequences).
// Latency: inputs driven 1ns after the rising edge, outputs sampled before the next edge.
// Backpressure: n/a.
module tb_cond_flag_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       CondLatch;
  logic       PCS;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       PCWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic       CondEx;
  logic [3:0] Flags;
`ifdef COND_PERF_CNT_EN
  logic       CntClr;
  logic [1:0] AnnulCnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cond_flag_unit #(
    .RESET_FLAGS (4'b0000)
`ifdef COND_PERF_CNT_EN
    , .CNT_W     (2)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .Cond      (Cond),
    .ALUFlags  (ALUFlags),
    .FlagW     (FlagW),
    .CondLatch (CondLatch),
    .PCS       (PCS),
    .NextPC    (NextPC),
    .RegW      (RegW),
    .MemW      (MemW),
    .PCWrite   (PCWrite),
    .RegWrite  (RegWrite),
    .MemWrite  (MemWrite),
    .CondEx    (CondEx),
    .Flags     (Flags)
`ifdef COND_PERF_CNT_EN
    , .CntClr  (CntClr)
    , .AnnulCnt(AnnulCnt)
`endif
  );

  typedef struct {
    logic [3:0] nzcv;
    logic [3:0] cond;
    logic       exp;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load an arbitrary NZCV value: latch AL so CondEx=1, then write both halves.
  task automatic set_flags(input logic [3:0] v);
    Cond = 4'b1110; CondLatch = 1'b1;
    tick();
    CondLatch = 1'b0; FlagW = 2'b11; ALUFlags = v;
    tick();
    FlagW = 2'b00;
  endtask

  task automatic eval(input logic [3:0] c);
    Cond = c; CondLatch = 1'b1;
    tick();
    CondLatch = 1'b0;
  endtask

  // Reference condition evaluation, written independently as arithmetic on flag bits.
  function automatic logic ref_cond(input logic [3:0] f, input logic [3:0] c);
    logic n, z, cc, v, base;
    n = f[3]; z = f[2]; cc = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cc;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cc && !z;
      3'd5: base = !(n ^ v);
      3'd6: base = !z && !(n ^ v);
      default: base = 1'b1;
    endcase
    if (c[3:1] == 3'd7) return 1'b1;
    return c[0] ? !base : base;
  endfunction

  initial begin
    vecs[0]  = '{4'b0100, 4'b0000, 1'b1};
    vecs[1]  = '{4'b0000, 4'b0000, 1'b0};
    vecs[2]  = '{4'b0000, 4'b0001, 1'b1};
    vecs[3]  = '{4'b0010, 4'b0010, 1'b1};
    vecs[4]  = '{4'b0010, 4'b0011, 1'b0};
    vecs[5]  = '{4'b1000, 4'b0100, 1'b1};
    vecs[6]  = '{4'b1000, 4'b0101, 1'b0};
    vecs[7]  = '{4'b0001, 4'b0110, 1'b1};
    vecs[8]  = '{4'b0001, 4'b0111, 1'b0};
    vecs[9]  = '{4'b0010, 4'b1000, 1'b1};
    vecs[10] = '{4'b0110, 4'b1000, 1'b0};
    vecs[11] = '{4'b0110, 4'b1001, 1'b1};
    vecs[12] = '{4'b1001, 4'b1010, 1'b1};
    vecs[13] = '{4'b1001, 4'b1011, 1'b0};
    vecs[14] = '{4'b1001, 4'b1100, 1'b1};
    vecs[15] = '{4'b1101, 4'b1101, 1'b1};
    vecs[16] = '{4'b1000, 4'b1011, 1'b1};
    vecs[17] = '{4'b1000, 4'b1010, 1'b0};
    vecs[18] = '{4'b0000, 4'b1110, 1'b1};
    vecs[19] = '{4'b0000, 4'b1111, 1'b1};
    vecs[20] = '{4'b1100, 4'b1100, 1'b0};
    vecs[21] = '{4'b0000, 4'b1001, 1'b1};

    reset = 1'b0; Cond = 4'b0000; ALUFlags = 4'b0000; FlagW = 2'b00; CondLatch = 1'b0;
    PCS = 1'b0; NextPC = 1'b1; RegW = 1'b1; MemW = 1'b0;
`ifdef COND_PERF_CNT_EN
    CntClr = 1'b0;
`endif
    tick();
    tick();

    // Reset state
    check("rst_flags", Flags, 4'b0000);
    check("rst_condex", CondEx, 1'b0);
    check("rst_pcwrite", PCWrite, 1'b1);
    check("rst_regwrite", RegWrite, 1'b0);

    reset = 1'b1;
    tick();
    eval(4'b1110);
    check("al_condex", CondEx, 1'b1);
    check("al_regwrite", RegWrite, 1'b1);
    NextPC = 1'b0; RegW = 1'b0; PCS = 1'b1; MemW = 1'b1;
    #1;
    check("al_pcwrite_pcs", PCWrite, 1'b1);
    check("al_memwrite", MemWrite, 1'b1);
    PCS = 1'b0; MemW = 1'b0;
    #1;
    check("pcwrite_idle", PCWrite, 1'b0);

    // Split flag writes
    ALUFlags = 4'b1111; FlagW = 2'b10;
    tick();
    check("split_nz", Flags, 4'b1100);
    ALUFlags = 4'b0000; FlagW = 2'b01;
    tick();
    check("split_cv0", Flags, 4'b1100);
    ALUFlags = 4'b0011; FlagW = 2'b01;
    tick();
    check("split_cv1", Flags, 4'b1111);
    FlagW = 2'b00;

    // Annulled instruction
    set_flags(4'b0100);
    check("annul_setflags", Flags, 4'b0100);
    eval(4'b0001);
    check("annul_condex", CondEx, 1'b0);
    RegW = 1'b1; MemW = 1'b1; PCS = 1'b1; NextPC = 1'b0; FlagW = 2'b11; ALUFlags = 4'b1010;
    #1;
    check("annul_regwrite", RegWrite, 1'b0);
    check("annul_memwrite", MemWrite, 1'b0);
    check("annul_pcwrite", PCWrite, 1'b0);
    tick();
    check("annul_flags_hold", Flags, 4'b0100);
    RegW = 1'b0; MemW = 1'b0; PCS = 1'b0; FlagW = 2'b00;

    // Table vectors
    for (int i = 0; i < 22; i++) begin
      set_flags(vecs[i].nzcv);
      eval(vecs[i].cond);
      check($sformatf("vec%0d_f%b_c%b", i, vecs[i].nzcv, vecs[i].cond), CondEx, vecs[i].exp);
    end

    // Sweep of compare conditions over all NZCV values
    for (int f = 0; f < 16; f++) begin
      for (int k = 0; k < 6; k++) begin
        logic [3:0] c;
        c = 4'(8 + k);
        set_flags(4'(f));
        eval(c);
        check($sformatf("sweep_f%b_c%b", 4'(f), c), CondEx, ref_cond(4'(f), c));
      end
    end

    // Same-cycle CondLatch and FlagW
    set_flags(4'b0000);
    Cond = 4'b0000; CondLatch = 1'b1; FlagW = 2'b11; ALUFlags = 4'b0100;
    tick();
    CondLatch = 1'b0; FlagW = 2'b00;
    check("same_cycle_flags", Flags, 4'b0100);
    check("same_cycle_condex", CondEx, 1'b0);

    // Asynchronous reset mid-instruction
    set_flags(4'b1010);
    RegW = 1'b1; MemW = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check("midrst_regwrite", RegWrite, 1'b0);
    check("midrst_memwrite", MemWrite, 1'b0);
    check("midrst_flags", Flags, 4'b0000);
    RegW = 1'b0; MemW = 1'b0;
    tick();
    reset = 1'b1;
    tick();

`ifdef COND_PERF_CNT_EN
    // Annul counter with 2-bit width
    CntClr = 1'b1;
    tick();
    CntClr = 1'b0;
    check("cnt_clr", AnnulCnt, 2'd0);
    set_flags(4'b0100);
    check("cnt_al_noinc", AnnulCnt, 2'd0);
    for (int i = 0; i < 4; i++) begin
      eval(4'b0001);
      check($sformatf("cnt_step%0d", i), AnnulCnt, (i < 3) ? (i + 1) : 3);
    end
    CntClr = 1'b1;
    eval(4'b0001);
    CntClr = 1'b0;
    check("cnt_clr_wins", AnnulCnt, 2'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cond_flag_unit.md
Name: cond_flag_unit

Overview:
- Consumer end of the ALU flag interface in the multicycle ARM datapath.
- Holds the architectural NZCV flag register and evaluates the 4-bit instruction condition field against it.
- Registers the condition result once per instruction and gates the controller's PC, register and memory write strobes for the rest of that instruction's multicycle sequence.
- Sits between the main FSM/decoder and the datapath write enables.

Parameters:
- RESET_FLAGS, 4'b0000, NZCV value loaded into the flag register on reset.
- CNT_W, 16, width of the annulled-instruction counter; used only when COND_PERF_CNT_EN is defined.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; state is cleared while reset==0.
- Cond  in  4  instruction condition field, Instr[31:28].
- ALUFlags  in  4  {N,Z,C,V} from the ALU, same bit order as Flags.
- FlagW  in  2  [1] requests an N,Z write; [0] requests a C,V write.
- CondLatch  in  1  pulse from the FSM in the Decode state; evaluate Cond and capture the result.
- PCS  in  1  instruction writes the PC (branch or Rd==15).
- NextPC  in  1  unconditional PC increment from the FSM.
- RegW  in  1  FSM register-file write request.
- MemW  in  1  FSM memory write request.
- PCWrite  out  1  gated PC write enable.
- RegWrite  out  1  gated register-file write enable.
- MemWrite  out  1  gated memory write enable.
- CondEx  out  1  registered condition result for the current instruction.
- Flags  out  4  current NZCV register, {N,Z,C,V}.

Behaviour:
- Reset (reset==0, asynchronous): Flags=RESET_FLAGS, CondEx=0. As a result RegWrite=0 and MemWrite=0, and PCWrite=NextPC.
- Condition evaluation is combinational on registered Flags, never on ALUFlags:
  - EQ 0000 Z; NE 0001 !Z; CS 0010 C; CC 0011 !C; MI 0100 N; PL 0101 !N; VS 0110 V; VC 0111 !V.
  - HI 1000 C&!Z; LS 1001 !C|Z; GE 1010 N==V; LT 1011 N!=V; GT 1100 !Z&(N==V); LE 1101 Z|(N!=V).
  - AL 1110 = 1. Code 1111 is also 1 (treated as AL).
- CondEx register: loads the evaluated result on a clk edge with CondLatch=1; otherwise it holds. One-cycle latency: gating takes effect the cycle after CondLatch.
- Flag register:
  - Flags[3:2] <= ALUFlags[3:2] when FlagW[1] & CondEx.
  - Flags[1:0] <= ALUFlags[1:0] when FlagW[0] & CondEx.
  - The two halves are independent; a half not enabled holds.
- Outputs, combinational from registered state:
  - PCWrite = NextPC | (PCS & CondEx)
  - RegWrite = RegW & CondEx
  - MemWrite = MemW & CondEx
- Simultaneous CondLatch and FlagW:
  - The flag write is gated by the old CondEx.
  - The new condition is evaluated on the old Flags.
  - The FSM never issues both together; the rule exists only for determinism.
- Flags written by instruction k are visible to the CondLatch of instruction k+1 provided at least one edge separates them.
- Reset asserted mid-instruction: everything is cleared immediately, so pending gated writes drop to 0.

Optional Feature:
- Macro: COND_PERF_CNT_EN.
- When defined, adds ports CntClr (in, 1) and AnnulCnt (out, CNT_W).
  - AnnulCnt increments on each CondLatch edge whose evaluated condition is 0.
  - It saturates at all-ones.
  - CntClr=1 synchronously clears it and wins over an increment in the same cycle.
  - Reset value is 0.
- When undefined, these ports and the counter logic do not exist; all other behaviour is identical.

Decomposition:
- Package arm_cond_pkg:
  - cond_e enum of the 16 condition codes.
  - Flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- Sub-module cond_check: purely combinational Cond + Flags -> result evaluator, reusable by a future pipelined core.

Test Plan:
- Reset: reset=0 with NextPC=1, RegW=1 -> Flags=0000, CondEx=0, PCWrite=1, RegWrite=0. Release reset, pulse CondLatch with Cond=1110 -> next cycle CondEx=1, RegWrite=1.
- Flag split write:
  - Flags=0000, CondEx=1, ALUFlags=1111, FlagW=10 -> Flags=1100.
  - Then FlagW=01 with ALUFlags=0000 -> Flags=1100 unchanged in C,V (already 0).
  - Then FlagW=01 with ALUFlags=0011 -> Flags=1111.
- Annulled instruction: Flags=0100 (Z=1), Cond=0001 (NE), CondLatch -> CondEx=0. Then RegW=1, MemW=1, PCS=1, NextPC=0, FlagW=11, ALUFlags=1010 -> RegWrite=MemWrite=PCWrite=0, Flags stays 0100.
- Signed compares: sweep all 16 NZCV values against GE/LT/GT/LE/HI/LS via CondLatch; CondEx must match the table. Example: Flags=1001 -> GE=1, LT=0, GT=1.
- Same-cycle CondLatch+FlagW: CondEx=1, Flags=0000, Cond=0000 (EQ), FlagW=11, ALUFlags=0100 -> Flags=0100 and CondEx=0, because EQ was evaluated on the old Z=0.
- COND_PERF_CNT_EN, CNT_W=2: four annulled CondLatch pulses -> AnnulCnt 1,2,3,3. Then CntClr together with an annulled latch -> AnnulCnt=0.
